crc_frame_checker: RTL and testbench
====================================

Name: crc_frame_checker

Overview:
- Receive-side frame sequencer for the serial work/result link.
- Accepts a byte stream delimited by in_last. Drives the existing CRC32 engine (polynomial 0x04C11DB7, init 0, unreflected) over the whole frame, including its 4-byte big-endian trailer, and checks for a zero residue.
- Strips the trailer via a 4-byte delay buffer and forwards payload bytes downstream.
- Reports per-frame status and keeps good/bad frame counters.

Parameters:
- MAX_LEN, 128: maximum frame length in bytes, CRC trailer included; must be ≥ 5.
- CNT_W, 16: width of the frame_count and err_count counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_byte  in  8  input byte
- in_last  in  1  marks the final byte of a frame (qualified by in_valid)
- in_ready  out  1  byte accepted when in_valid & in_ready
- out_valid  out  1  payload byte valid, one-cycle strobe, no backpressure
- out_byte  out  8  payload byte
- frame_done  out  1  one-cycle pulse at end of every frame
- frame_ok  out  1  valid with frame_done: CRC good, length legal, no overflow
- err_crc  out  1  valid with frame_done: nonzero residue
- err_len  out  1  valid with frame_done: length < 5 or > MAX_LEN
- frame_count  out  CNT_W  good frames, wraps
- err_count  out  CNT_W  bad frames, wraps

Behaviour:
- Reset (async assert, sync deassert by the system):
  - All outputs 0; state IDLE; length counter 0; buffer emptied.
  - Reset mid-frame silently discards the partial frame. No frame_done, no counter change.
- States: IDLE, RECV, CHECK.
- IDLE: in_ready=1.
  - On accept, drive CRC engine rx_we=1 and its sync reset=1 in the same cycle, so the CRC restarts and absorbs byte 0 with no gap.
  - Push the byte into the buffer; len=1.
  - If in_last is also set, go to CHECK; otherwise go to RECV.
- RECV: in_ready=1. On accept:
  - Drive CRC rx_we=1 with its reset=0.
  - Shift the byte into the buffer.
  - If the buffer held 4 bytes before the shift, register the oldest byte to out_byte with out_valid=1 in the next cycle, unless overflow is set.
  - len increments and saturates at MAX_LEN+1. Reaching MAX_LEN+1 sets sticky overflow, which suppresses further output; bytes are still consumed up to in_last.
  - Accepting an in_last byte moves the FSM to CHECK.
- CHECK: exactly one cycle, in_ready=0, CRC register holds the final residue. Next cycle, registered for one cycle:
  - frame_done=1.
  - err_crc = (residue != 0).
  - err_len = (len < 5) | overflow.
  - frame_ok = ~err_crc & ~err_len.
  - frame_count++ if frame_ok, else err_count++.
  - State returns to IDLE.
- Timing: last byte accepted in cycle T → in_ready low in T+1 only; frame_done in T+2; a new frame may start in T+2.
- Frames shorter than 5 bytes emit no payload.
- Payload already emitted before a failure is not recalled. The consumer discards it when frame_ok=0.
- CRC engine is idle (rx_we=0, reset=0) whenever no byte is accepted.
- Counters wrap modulo 2^CNT_W.

Optional Feature:
- CRC_FRAME_TIMEOUT_EN: adds a parameter TIMEOUT_CYCLES, default 50000.
  - In RECV, an idle counter resets on every accepted byte.
  - When the idle counter reaches TIMEOUT_CYCLES, the FSM goes to CHECK with forced err_len=1 and err_crc=0, reporting a bad frame; err_count increments.
- Without the macro, RECV waits indefinitely and there is no timer logic.

Decomposition:
- Shared package:
  - state enum (IDLE, RECV, CHECK)
  - MIN_FRAME_LEN=5
  - CRC_LEN=4
  - CRC residue constant 32'h0
- One sub-module: the existing CRC32 engine, instantiated unchanged. The controller drives its rx_we, rx_byte and sync reset.
- The delay buffer stays inline.

Test Plan:
- Good frame: bytes 01 04 C1 1D B7 (last on B7) → single out_byte 01; frame_done with frame_ok=1; frame_count=1; in_ready low exactly one cycle after B7.
- Bad CRC: 01 04 C1 1D B6 → out_byte 01 emitted; frame_done with err_crc=1, frame_ok=0; err_count=1.
- Short frame: 04 C1 1D B7 → no out_valid; err_len=1; err_count+1.
- Overflow, MAX_LEN=8, 10-byte frame → first 4 payload bytes out, no further output; err_len=1.
- Back-to-back good frames (second starts at T+2) → two frame_done pulses; frame_count=2; the CRC restart does not leak state between frames.
- reset_n low mid-frame after 3 bytes, then the good frame → no frame_done for the partial frame; the good frame passes.
- With CRC_FRAME_TIMEOUT_EN: TIMEOUT_CYCLES=100 and a 100-cycle gap → frame_done with err_len=1.

Source files
------------

// File: rtl/crc_frame_checker_pkg.sv
// Shared types and constants for the CRC frame checker: FSM states, frame
// geometry, and the byte-wise CRC32 update (poly 0x04C11DB7, MSB first).
package crc_frame_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam int          MIN_FRAME_LEN = 5;
   localparam int          CRC_LEN       = 4;
   localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT      = 32'h0000_0000;
   localparam logic [31:0] CRC_RESIDUE   = 32'h0000_0000;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[31] ^ data[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc_frame_checker_crc32.sv
// CRC32 engine: unreflected, init 0, one byte per rx_we. A sync reset
// together with rx_we restarts the CRC and absorbs that byte in one cycle.
module crc_frame_checker_crc32
   import crc_frame_checker_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        srst,
   input  logic        rx_we,
   input  logic [7:0]  rx_byte,
   output logic [31:0] crc
);

   logic [31:0] crc_r;

   // CRC register update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_r <= CRC_INIT;
      end else if (srst) begin
         crc_r <= rx_we ? crc32_byte(CRC_INIT, rx_byte) : CRC_INIT;
      end else if (rx_we) begin
         crc_r <= crc32_byte(crc_r, rx_byte);
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side frame sequencer: CRC check, trailer stripping, status and counters.
// Optional idle timeout in RECV is enabled by defining CRC_FRAME_TIMEOUT_EN.
module crc_frame_checker
   import crc_frame_checker_pkg::*;
#(
   parameter int MAX_LEN = 128,
   parameter int CNT_W   = 16
`ifdef CRC_FRAME_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 50000
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [7:0]       in_byte,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_byte,
   output logic             frame_done,
   output logic             frame_ok,
   output logic             err_crc,
   output logic             err_len,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int             LEN_W   = $clog2(MAX_LEN + 2);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

   state_t           state_r;
   logic [LEN_W-1:0] len_r;
   logic             ovf_r;
   logic [7:0]       dly_r [CRC_LEN];
   logic [2:0]       dly_cnt_r;
   logic             in_ready_r, out_valid_r, frame_done_r, frame_ok_r, err_crc_r, err_len_r;
   logic [7:0]       out_byte_r;
   logic [CNT_W-1:0] frame_count_r, err_count_r;

   logic             accept_s, crc_srst_s, dly_full_s, emit_s;
   logic             chk_err_crc_s, chk_err_len_s, chk_ok_s;
   logic [LEN_W-1:0] len_next_s;
   logic [31:0]      crc_s;

`ifdef CRC_FRAME_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_r;
   logic            to_flag_r;
`endif

   assign accept_s   = in_valid & in_ready_r;
   assign crc_srst_s = accept_s & (state_r == ST_IDLE);

   crc_frame_checker_crc32 u_crc (
      .clk     (clk),
      .rst_n   (reset_n),
      .srst    (crc_srst_s),
      .rx_we   (accept_s),
      .rx_byte (in_byte),
      .crc     (crc_s)
   );

   // Length saturation, payload release decision and end-of-frame verdict
   always_comb begin
      len_next_s = len_r;
      if (len_r == LEN_SAT) begin
         len_next_s = len_r;
      end else begin
         len_next_s = len_r + LEN_W'(1);
      end
      dly_full_s = (dly_cnt_r == 3'(CRC_LEN));
      // The byte that trips overflow must not release its oldest buffered byte
      emit_s     = dly_full_s & ~ovf_r & (len_next_s != LEN_SAT);
`ifdef CRC_FRAME_TIMEOUT_EN
      chk_err_crc_s = to_flag_r ? 1'b0 : (crc_s != CRC_RESIDUE);
      chk_err_len_s = to_flag_r ? 1'b1 : ((len_r < LEN_W'(MIN_FRAME_LEN)) | ovf_r);
`else
      chk_err_crc_s = (crc_s != CRC_RESIDUE);
      chk_err_len_s = (len_r < LEN_W'(MIN_FRAME_LEN)) | ovf_r;
`endif
      chk_ok_s = ~chk_err_crc_s & ~chk_err_len_s;
   end

   // Frame FSM with trailer delay buffer and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         len_r         <= '0;
         ovf_r         <= 1'b0;
         dly_cnt_r     <= 3'd0;
         for (int i = 0; i < CRC_LEN; i++) dly_r[i] <= 8'h00;
         in_ready_r    <= 1'b0;
         out_valid_r   <= 1'b0;
         out_byte_r    <= 8'h00;
         frame_done_r  <= 1'b0;
         frame_ok_r    <= 1'b0;
         err_crc_r     <= 1'b0;
         err_len_r     <= 1'b0;
         frame_count_r <= '0;
         err_count_r   <= '0;
`ifdef CRC_FRAME_TIMEOUT_EN
         to_cnt_r      <= '0;
         to_flag_r     <= 1'b0;
`endif
      end else begin
         out_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
         frame_ok_r   <= 1'b0;
         err_crc_r    <= 1'b0;
         err_len_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               in_ready_r <= 1'b1;
               if (accept_s) begin
                  dly_r[0]  <= in_byte;
                  dly_cnt_r <= 3'd1;
                  len_r     <= LEN_W'(1);
                  ovf_r     <= 1'b0;
`ifdef CRC_FRAME_TIMEOUT_EN
                  to_cnt_r  <= '0;
                  to_flag_r <= 1'b0;
`endif
                  if (in_last) begin
                     state_r    <= ST_CHECK;
                     in_ready_r <= 1'b0;
                  end else begin
                     state_r <= ST_RECV;
                  end
               end
            end
            ST_RECV: begin
               if (accept_s) begin
                  for (int i = CRC_LEN - 1; i > 0; i--) dly_r[i] <= dly_r[i-1];
                  dly_r[0] <= in_byte;
                  if (!dly_full_s) dly_cnt_r <= dly_cnt_r + 3'd1;
                  len_r <= len_next_s;
                  if (len_next_s == LEN_SAT) ovf_r <= 1'b1;
                  if (emit_s) begin
                     out_valid_r <= 1'b1;
                     out_byte_r  <= dly_r[CRC_LEN-1];
                  end
`ifdef CRC_FRAME_TIMEOUT_EN
                  to_cnt_r <= '0;
`endif
                  if (in_last) begin
                     state_r    <= ST_CHECK;
                     in_ready_r <= 1'b0;
                  end
               end
`ifdef CRC_FRAME_TIMEOUT_EN
               else if (to_cnt_r == TO_LAST) begin
                  state_r    <= ST_CHECK;
                  in_ready_r <= 1'b0;
                  to_flag_r  <= 1'b1;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
`endif
            end
            ST_CHECK: begin
               frame_done_r <= 1'b1;
               err_crc_r    <= chk_err_crc_s;
               err_len_r    <= chk_err_len_s;
               frame_ok_r   <= chk_ok_s;
               if (chk_ok_s) frame_count_r <= frame_count_r + CNT_W'(1);
               else          err_count_r   <= err_count_r + CNT_W'(1);
               dly_cnt_r    <= 3'd0;
               in_ready_r   <= 1'b1;
               state_r      <= ST_IDLE;
            end
            default: begin
               state_r    <= ST_IDLE;
               in_ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_byte    = out_byte_r;
   assign frame_done  = frame_done_r;
   assign frame_ok    = frame_ok_r;
   assign err_crc     = err_crc_r;
   assign err_len     = err_len_r;
   assign frame_count = frame_count_r;
   assign err_count   = err_count_r;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench for crc_frame_checker (MAX_LEN=8); timeout scenario runs
// only when CRC_FRAME_TIMEOUT_EN is defined.
module tb_crc_frame_checker;

   localparam int MAXL = 8;
   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        reset_n, in_valid, in_last;
   logic [7:0]  in_byte;
   logic        in_ready, out_valid, frame_done, frame_ok, err_crc, err_len;
   logic [7:0]  out_byte;
   logic [15:0] frame_count, err_count;

   int total = 0;
   int bad   = 0;
   int done_seen = 0;
   int exp_good = 0;
   int exp_bad  = 0;
   logic [7:0]  exp_bytes[$];
   logic [34:0] exp_stat[$];
   logic [7:0]  mon_b;
   logic [34:0] mon_s, obs_s;

   always #5 clk = ~clk;

   crc_frame_checker #(
      .MAX_LEN(MAXL),
      .CNT_W(16)
`ifdef CRC_FRAME_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_byte(in_byte),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_byte(out_byte),
      .frame_done(frame_done), .frame_ok(frame_ok), .err_crc(err_crc), .err_len(err_len),
      .frame_count(frame_count), .err_count(err_count)
   );

   function automatic logic [31:0] crc_of(input bq_t q);
      logic [31:0] c = 32'h0;
      foreach (q[i]) begin
         c ^= {q[i], 24'h0};
         for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      return c;
   endfunction

   function automatic bq_t make_good(input bq_t p);
      bq_t f = p;
      logic [31:0] c = crc_of(p);
      f.push_back(c[31:24]); f.push_back(c[23:16]); f.push_back(c[15:8]); f.push_back(c[7:0]);
      return f;
   endfunction

   // Scoreboard: pop expected payload bytes and frame status as the DUT emits them
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (out_valid === 1'b1) begin
            total++;
            if (exp_bytes.size() == 0) begin
               bad++;
               $display("FAIL out_byte_unexpected: got %h, expected no output", out_byte);
            end else begin
               mon_b = exp_bytes.pop_front();
               if (out_byte !== mon_b) begin
                  bad++;
                  $display("FAIL out_byte: got %h, expected %h", out_byte, mon_b);
               end
            end
         end
         if (frame_done === 1'b1) begin
            done_seen++;
            total++;
            obs_s = {frame_ok, err_crc, err_len, frame_count, err_count};
            if (exp_stat.size() == 0) begin
               bad++;
               $display("FAIL frame_done_unexpected: got status %h, expected none", obs_s);
            end else begin
               mon_s = exp_stat.pop_front();
               if (obs_s !== mon_s) begin
                  bad++;
                  $display("FAIL frame_status {ok,crc,len,fc,ec}: got %h, expected %h", obs_s, mon_s);
               end
            end
         end
      end
   end

   // Push model expectations for one frame, then drive it (entry and exit on a negedge)
   task automatic run_frame(input bq_t fr, output int stalls);
      int L = fr.size();
      logic [31:0] c = crc_of(fr);
      logic ov, el, ec, ok;
      int n_emit, g;
      ov = (L > MAXL);
      el = (L < 5) || ov;
      ec = (c != 32'h0);
      ok = !el && !ec;
      n_emit = ((L < MAXL) ? L : MAXL) - 4;
      for (int i = 0; i < n_emit; i++) exp_bytes.push_back(fr[i]);
      if (ok) exp_good++; else exp_bad++;
      exp_stat.push_back({ok, ec, el, 16'(exp_good), 16'(exp_bad)});
      stalls = 0;
      for (int i = 0; i < L; i++) begin
         in_valid = 1'b1; in_byte = fr[i]; in_last = (i == L - 1);
         g = 0;
         while (in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; stalls++; end
         if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got %b, expected 1 within 20 cycles", in_ready);
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0; in_last = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
      repeat (3) @(negedge clk);
      total++;
      if ({in_ready, out_valid, out_byte, frame_done, frame_ok, err_crc, err_len, frame_count, err_count} !== 47'h0) begin
         bad++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic test_good;
      bq_t f = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
      int s;
      run_frame(f, s);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL good_ready_low: got %b, expected 0", in_ready); end
      @(negedge clk);
      total++;
      if ({in_ready, frame_done, frame_ok} !== 3'b111) begin
         bad++; $display("FAIL good_t2 {ready,done,ok}: got %b, expected 111", {in_ready, frame_done, frame_ok});
      end
      @(negedge clk);
      total++;
      if (exp_bytes.size() != 0 || exp_stat.size() != 0 || frame_count !== 16'd1) begin
         bad++; $display("FAIL good_drain: got pend=%0d/%0d fc=%0d, expected 0/0 1", exp_bytes.size(), exp_stat.size(), frame_count);
      end
   endtask

   task automatic test_bad_crc;
      bq_t f = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB6};
      int s;
      run_frame(f, s);
      repeat (3) @(negedge clk);
      total++;
      if (exp_bytes.size() != 0 || exp_stat.size() != 0 || err_count !== 16'(exp_bad)) begin
         bad++; $display("FAIL bad_crc: got pend=%0d/%0d ec=%0d, expected 0/0 %0d", exp_bytes.size(), exp_stat.size(), err_count, exp_bad);
      end
   endtask

   task automatic test_short;
      bq_t f = '{8'h04, 8'hC1, 8'h1D, 8'hB7};
      int s;
      run_frame(f, s);
      repeat (3) @(negedge clk);
      total++;
      if (exp_stat.size() != 0 || err_count !== 16'(exp_bad) || frame_count !== 16'(exp_good)) begin
         bad++; $display("FAIL short: got pend=%0d ec=%0d fc=%0d, expected 0 %0d %0d", exp_stat.size(), err_count, frame_count, exp_bad, exp_good);
      end
   endtask

   task automatic test_overflow;
      bq_t f;
      int s;
      for (int i = 0; i < 10; i++) f.push_back(8'(8'h10 + i));
      run_frame(f, s);
      repeat (3) @(negedge clk);
      total++;
      if (exp_bytes.size() != 0 || exp_stat.size() != 0 || err_count !== 16'(exp_bad)) begin
         bad++; $display("FAIL overflow: got pend=%0d/%0d ec=%0d, expected 0/0 %0d", exp_bytes.size(), exp_stat.size(), err_count, exp_bad);
      end
   endtask

   task automatic test_max_len;
      bq_t p;
      int s;
      for (int i = 0; i < MAXL - 4; i++) p.push_back(8'($urandom_range(0, 255)));
      run_frame(make_good(p), s);
      repeat (3) @(negedge clk);
      total++;
      if (exp_bytes.size() != 0 || exp_stat.size() != 0 || frame_count !== 16'(exp_good)) begin
         bad++; $display("FAIL max_len: got pend=%0d/%0d fc=%0d, expected 0/0 %0d", exp_bytes.size(), exp_stat.size(), frame_count, exp_good);
      end
   endtask

   task automatic test_back_to_back;
      bq_t p1, p2;
      int s1, s2, d0;
      for (int i = 0; i < 3; i++) begin
         p1.push_back(8'($urandom_range(0, 255)));
         p2.push_back(8'($urandom_range(0, 255)));
      end
      d0 = done_seen;
      run_frame(make_good(p1), s1);
      run_frame(make_good(p2), s2);
      total++;
      if (s2 != 1) begin bad++; $display("FAIL b2b_restart_stall: got %0d, expected 1", s2); end
      repeat (3) @(negedge clk);
      total++;
      if (done_seen - d0 != 2 || frame_count !== 16'(exp_good) || exp_stat.size() != 0) begin
         bad++; $display("FAIL b2b_done: got pulses=%0d fc=%0d, expected 2 %0d", done_seen - d0, frame_count, exp_good);
      end
   endtask

   task automatic test_reset_mid;
      bq_t f = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
      int s, d0;
      d0 = done_seen;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_byte = 8'(8'hA0 + i); in_last = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      reset_n = 1'b0;
      exp_good = 0; exp_bad = 0;
      @(negedge clk);
      total++;
      if ({frame_done, out_valid, frame_count, err_count} !== 34'h0) begin
         bad++; $display("FAIL midreset_outputs: got nonzero, expected all 0");
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (done_seen != d0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses, expected 0", done_seen - d0); end
      run_frame(f, s);
      repeat (3) @(negedge clk);
      total++;
      if (frame_count !== 16'd1 || err_count !== 16'd0 || exp_stat.size() != 0) begin
         bad++; $display("FAIL midreset_good: got fc=%0d ec=%0d, expected 1 0", frame_count, err_count);
      end
   endtask

`ifdef CRC_FRAME_TIMEOUT_EN
   task automatic test_timeout;
      int w;
      exp_bad++;
      exp_stat.push_back({1'b0, 1'b0, 1'b1, 16'(exp_good), 16'(exp_bad)});
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_byte = 8'(8'h55 + i); in_last = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      w = 0;
      while (frame_done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      total++;
      if (w < 100 || w > 102) begin bad++; $display("FAIL timeout_latency: got %0d cycles, expected 100..102", w); end
      repeat (2) @(negedge clk);
      total++;
      if (exp_stat.size() != 0 || err_count !== 16'(exp_bad)) begin
         bad++; $display("FAIL timeout_status: got pend=%0d ec=%0d, expected 0 %0d", exp_stat.size(), err_count, exp_bad);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_good();
      test_bad_crc();
      test_short();
      test_overflow();
      test_max_len();
      test_back_to_back();
      test_reset_mid();
`ifdef CRC_FRAME_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
